dcp_recover_pipe: RTL and testbench

DCP_RECOVER_PIPE -- requirements
Module: dcp_recover_pipe

---
 rtl/dcp_recover_pipe_pkg.sv | 17 +
 rtl/dcp_recover_pipe_if.sv | 29 ++
 rtl/dcp_recip_lut.sv | 26 ++
 rtl/dcp_recover_pipe.sv | 132 +++++++++++++
 tb/tb_dcp_recover_pipe.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dcp_recover_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the dehaze recovery pipeline.
package dcp_recover_pipe_pkg;

  localparam int unsigned PIPE_LATENCY = 4;

  // Reciprocal entry floor((2^tw-1)*2^fb / max(t,t0)); the clamp keeps low addresses finite.
  function automatic longint unsigned recip_entry(input longint unsigned t,
                                                  input int unsigned tw,
                                                  input int unsigned fb,
                                                  input int unsigned t0);
    longint unsigned te;
    te = (t < longint'(t0)) ? longint'(t0) : t;
    if (te == 0) te = 1;
    return (((64'd1 << tw) - 64'd1) << fb) / te;
  endfunction

endpackage

// File: rtl/dcp_recover_pipe_if.sv
// Pixel bus for dcp_recover_pipe: hazy pixel in, recovered pixel and frame stats out.
interface dcp_recover_pipe_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned CH  = 3,
  parameter int unsigned TW  = 8,
  parameter int unsigned SBW = 2
);
  logic               i_data_valid;
  logic               i_sof;
  logic [CH*DW-1:0]   i_rgb;
  logic [TW-1:0]      i_transmittance;
  logic [CH*DW-1:0]   i_atmos;
  logic               i_bypass;
  logic [SBW-1:0]     i_sideband;
  logic [CH*DW-1:0]   o_defogging;
  logic               o_data_valid;
  logic [SBW-1:0]     o_sideband;
  logic [15:0]        o_sat_frame;

  modport master (
    output i_data_valid, i_sof, i_rgb, i_transmittance, i_atmos, i_bypass, i_sideband,
    input  o_defogging, o_data_valid, o_sideband, o_sat_frame
  );

  modport slave (
    input  i_data_valid, i_sof, i_rgb, i_transmittance, i_atmos, i_bypass, i_sideband,
    output o_defogging, o_data_valid, o_sideband, o_sat_frame
  );
endinterface

// File: rtl/dcp_recip_lut.sv
// Synchronous reciprocal ROM indexed by effective transmittance, filled at elaboration.
module dcp_recip_lut
  import dcp_recover_pipe_pkg::*;
#(
  parameter int unsigned TW = 8,
  parameter int unsigned FB = 12,
  parameter int unsigned T0 = 26
) (
  input  logic            i_clk,
  input  logic            i_en,
  input  logic [TW-1:0]   i_addr,
  output logic [TW+FB:0]  o_recip
);
  localparam int unsigned RW    = TW + FB + 1;
  localparam int unsigned DEPTH = 2 ** TW;

  logic [RW-1:0] w_rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign w_rom[a] = RW'(recip_entry(longint'(a), TW, FB, T0));
  end

  always_ff @(posedge i_clk) begin
    if (i_en) o_recip <= w_rom[i_addr];
  end
endmodule

// File: rtl/dcp_recover_pipe.sv
// Four-stage dark-channel-prior recovery J = (I-A)/t + A with clip and per-frame saturation count.
module dcp_recover_pipe
  import dcp_recover_pipe_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned CH  = 3,
  parameter int unsigned TW  = 8,
  parameter int unsigned FB  = 12,
  parameter int unsigned T0  = 26,
  parameter int unsigned SBW = 2
) (
  input  logic             pixelclk,
  input  logic             reset,
  dcp_recover_pipe_if.slave bus
);
  localparam int unsigned RW = TW + FB + 1;
  localparam int unsigned PW = DW + 1 + RW + 1;
  localparam int unsigned NS = PIPE_LATENCY - 1;
  localparam logic signed [PW:0] QMAX = (PW+1)'((2 ** DW) - 1);

  typedef struct packed {
    logic             valid;
    logic             sof;
    logic             bypass;
    logic [SBW-1:0]   sb;
    logic [CH*DW-1:0] rgb;
    logic [CH*DW-1:0] atmos;
    logic [TW-1:0]    teff;
  } ctl_t;

  ctl_t             r_ctl [NS];
  ctl_t             w_in;
  logic [RW-1:0]    w_recip;
  logic [CH*DW-1:0] w_q_sat;
  logic [CH-1:0]    w_clip;
  logic             w_sat;
  logic [CH*DW-1:0] r_defog;
  logic             r_out_v;
  logic [SBW-1:0]   r_sb;
  logic [15:0]      r_cnt;
  logic [15:0]      r_sat_frame;

  always_comb begin
    w_in        = '0;
    w_in.valid  = bus.i_data_valid;
    w_in.sof    = bus.i_sof;
    w_in.bypass = bus.i_bypass;
    w_in.sb     = bus.i_sideband;
    w_in.rgb    = bus.i_rgb;
    w_in.atmos  = bus.i_atmos;
    w_in.teff   = (bus.i_transmittance < TW'(T0)) ? TW'(T0) : bus.i_transmittance;
  end

  // Control/side data rides alongside the datapath; each slot only loads on a valid upstream slot.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NS; k++) r_ctl[k] <= '0;
    end else begin
      if (w_in.valid) r_ctl[0] <= w_in;
      else            r_ctl[0].valid <= 1'b0;
      for (int unsigned k = 1; k < NS; k++) begin
        if (r_ctl[k-1].valid) r_ctl[k] <= r_ctl[k-1];
        else                  r_ctl[k].valid <= 1'b0;
      end
    end
  end

  dcp_recip_lut #(.TW(TW), .FB(FB), .T0(T0)) u_recip_lut (
    .i_clk   (pixelclk),
    .i_en    (r_ctl[0].valid),
    .i_addr  (r_ctl[0].teff),
    .o_recip (w_recip)
  );

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW:0]   r_diff1;
    logic signed [DW:0]   r_diff2;
    logic signed [PW-1:0] r_prod;
    logic signed [PW-1:0] w_shift;
    logic signed [PW:0]   w_q;
    logic [DW-1:0]        w_a;

    always_ff @(posedge pixelclk or posedge reset) begin
      if (reset) begin
        r_diff1 <= '0;
        r_diff2 <= '0;
        r_prod  <= '0;
      end else begin
        if (bus.i_data_valid)
          r_diff1 <= $signed({1'b0, bus.i_rgb[c*DW +: DW]}) - $signed({1'b0, bus.i_atmos[c*DW +: DW]});
        if (r_ctl[0].valid) r_diff2 <= r_diff1;
        if (r_ctl[1].valid) r_prod  <= PW'(r_diff2) * PW'($signed({1'b0, w_recip}));
      end
    end

    assign w_a     = r_ctl[NS-1].atmos[c*DW +: DW];
    assign w_shift = r_prod >>> FB;
    assign w_q     = (PW+1)'(w_shift) + (PW+1)'($signed({1'b0, w_a}));
    assign w_clip[c] = (w_q < 0) || (w_q > QMAX);
    assign w_q_sat[c*DW +: DW] = (w_q < 0) ? '0 : ((w_q > QMAX) ? '1 : w_q[DW-1:0]);
  end

  assign w_sat = (|w_clip) && !r_ctl[NS-1].bypass;

  // An sof pixel closes the previous frame's count and seeds the new one with its own flag.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_out_v     <= 1'b0;
      r_defog     <= '0;
      r_sb        <= '0;
      r_cnt       <= '0;
      r_sat_frame <= '0;
    end else begin
      r_out_v <= r_ctl[NS-1].valid;
      if (r_ctl[NS-1].valid) begin
        r_defog <= r_ctl[NS-1].bypass ? r_ctl[NS-1].rgb : w_q_sat;
        r_sb    <= r_ctl[NS-1].sb;
        if (r_ctl[NS-1].sof) begin
          r_sat_frame <= r_cnt;
          r_cnt       <= {15'd0, w_sat};
        end else if (w_sat && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.o_defogging  = r_defog;
  assign bus.o_data_valid = r_out_v;
  assign bus.o_sideband   = r_sb;
  assign bus.o_sat_frame  = r_sat_frame;
endmodule

// File: tb/tb_dcp_recover_pipe.sv
// Scoreboard bench for dcp_recover_pipe: driver pushes model results, negedge monitor pops and compares.
module tb_dcp_recover_pipe;
  localparam int unsigned DW = 8, CH = 3, TW = 8, FB = 12, T0 = 26, SBW = 2;

  logic pixelclk = 1'b0;
  logic reset    = 1'b1;
  always #5 pixelclk = ~pixelclk;

  dcp_recover_pipe_if #(.DW(DW), .CH(CH), .TW(TW), .SBW(SBW)) bus ();

  dcp_recover_pipe #(.DW(DW), .CH(CH), .TW(TW), .FB(FB), .T0(T0), .SBW(SBW)) dut (
    .pixelclk (pixelclk),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    longint      due;
    logic [23:0] rgb;
    logic [1:0]  sb;
    logic [15:0] frame;
  } exp_t;

  exp_t        sb_q[$];
  longint      cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int unsigned m_cnt = 0;
  logic [15:0] m_frame = '0;
  logic [23:0] last_out = '0;

  always @(posedge pixelclk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // J = floor((I-A)*R/2^FB) + A, R = floor(255*4096/max(t,T0)), clipped to 0..255.
  function automatic logic [7:0] ref_chan(input int i, input int a, input int t, output bit clip);
    longint r, p, f, j;
    r = (longint'(255) * 4096) / ((t < int'(T0)) ? int'(T0) : t);
    p = longint'(i - a) * r;
    f = (p >= 0) ? p / 4096 : -((-p + 4095) / 4096);
    j = f + a;
    clip = (j < 0) || (j > 255);
    if (j < 0) return 8'd0;
    if (j > 255) return 8'd255;
    return 8'(j);
  endfunction

  task automatic drive(input bit v, input bit sof, input logic [23:0] rgb, input logic [7:0] t,
                       input logic [23:0] atm, input bit byp, input logic [1:0] sbd);
    exp_t        e;
    bit          clip, sat;
    logic [23:0] j;
    @(posedge pixelclk);
    #1;
    bus.i_data_valid    = v;
    bus.i_sof           = sof;
    bus.i_rgb           = rgb;
    bus.i_transmittance = t;
    bus.i_atmos         = atm;
    bus.i_bypass        = byp;
    bus.i_sideband      = sbd;
    if (v) begin
      sat = 1'b0;
      j   = rgb;
      if (!byp) begin
        for (int c = 0; c < 3; c++) begin
          j[c*8 +: 8] = ref_chan(int'(rgb[c*8 +: 8]), int'(atm[c*8 +: 8]), int'(t), clip);
          sat |= clip;
        end
      end
      if (sof) begin
        m_frame = 16'(m_cnt);
        m_cnt   = sat ? 1 : 0;
      end else if (sat && m_cnt < 65535) begin
        m_cnt++;
      end
      e.due   = cyc + 4;
      e.rgb   = j;
      e.sb    = sbd;
      e.frame = m_frame;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge pixelclk) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check("out_valid", longint'(bus.o_data_valid), 1);
      check("pixel", longint'(bus.o_defogging), longint'(e.rgb));
      check("sideband", longint'(bus.o_sideband), longint'(e.sb));
      check("sat_frame", longint'(bus.o_sat_frame), longint'(e.frame));
      last_out = e.rgb;
    end else begin
      check("idle_valid", longint'(bus.o_data_valid), 0);
      check("hold_pixel", longint'(bus.o_defogging), longint'(last_out));
    end
  end

  initial begin
    int k;
    bus.i_data_valid    = 1'b0;
    bus.i_sof           = 1'b0;
    bus.i_rgb           = '0;
    bus.i_transmittance = '0;
    bus.i_atmos         = '0;
    bus.i_bypass        = 1'b0;
    bus.i_sideband      = '0;
    repeat (3) @(posedge pixelclk);
    #1;
    check("rst_valid", longint'(bus.o_data_valid), 0);
    check("rst_pixel", longint'(bus.o_defogging), 0);
    check("rst_sideband", longint'(bus.o_sideband), 0);
    check("rst_sat_frame", longint'(bus.o_sat_frame), 0);
    reset = 1'b0;

    drive(1, 0, 24'h102030, 8'd255, 24'hFFFFFF, 0, 2'd1);
    drive(1, 0, 24'h323232, 8'd128, 24'hC8C8C8, 0, 2'd2);
    drive(1, 0, 24'hD2D2D2, 8'd10,  24'hC8C8C8, 0, 2'd3);
    repeat (5) drive(0, 0, '0, '0, '0, 0, '0);

    drive(1, 1, 24'h405060, 8'd255, 24'hFFFFFF, 0, 2'd0);
    for (int i = 0; i < 5; i++)
      drive(1, 0, (i % 2 == 0) ? 24'h323232 : 24'hD2D2D2, (i % 2 == 0) ? 8'd128 : 8'd10,
            24'hC8C8C8, 0, 2'(i));
    drive(1, 1, 24'h405060, 8'd255, 24'hFFFFFF, 0, 2'd1);
    drive(1, 0, 24'h111111, 8'd255, 24'hFFFFFF, 0, 2'd2);
    drive(1, 1, 24'h222222, 8'd255, 24'hFFFFFF, 0, 2'd3);
    repeat (5) drive(0, 0, '0, '0, '0, 0, '0);

    for (int i = 0; i < 16; i++)
      drive(i % 2 == 0, 0, 24'($urandom), 8'($urandom), 24'($urandom), 1, 2'($urandom));
    repeat (5) drive(0, 0, '0, '0, '0, 0, '0);

    for (int i = 0; i < 3; i++)
      drive(1, 0, 24'($urandom), 8'($urandom), 24'($urandom), 0, 2'($urandom));
    @(posedge pixelclk);
    #1;
    bus.i_data_valid = 1'b0;
    #2;
    reset = 1'b1;
    sb_q.delete();
    m_cnt    = 0;
    m_frame  = '0;
    last_out = '0;
    #1;
    check("midrst_valid", longint'(bus.o_data_valid), 0);
    check("midrst_pixel", longint'(bus.o_defogging), 0);
    check("midrst_sat_frame", longint'(bus.o_sat_frame), 0);
    repeat (2) @(posedge pixelclk);
    #1;
    reset = 1'b0;
    repeat (8) drive(0, 0, '0, '0, '0, 0, '0);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 24'($urandom),
            8'($urandom_range(0, 255)), 24'($urandom), $urandom_range(0, 4) == 0, 2'($urandom));
    repeat (5) drive(0, 0, '0, '0, '0, 0, '0);

    drive(1, 1, 24'h405060, 8'd255, 24'hFFFFFF, 0, 2'd0);
    for (int i = 0; i < 65540; i++)
      drive(1, 0, 24'hD2D2D2, 8'd10, 24'hC8C8C8, 0, 2'(i));
    drive(1, 1, 24'h405060, 8'd255, 24'hFFFFFF, 0, 2'd1);
    drive(0, 0, '0, '0, '0, 0, '0);

    k = 0;
    while (sb_q.size() > 0 && k < 50) begin
      @(posedge pixelclk);
      k++;
    end
    check("drain_empty", longint'(sb_q.size()), 0);
    repeat (3) @(posedge pixelclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
